// File: rtl/aes_pkg.sv
// Shared AES types, sizes, FSM states and byte-level helpers (S-box, round constant).
package aes_pkg;

  typedef logic [15:0][7:0] aes_block_t;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_NUM_RKEYS  = 11;

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_scheduler_keyexpand.sv
// keyexpand: one combinational AES-128 key-expansion round (round key rc -> rc+1).
module keyexpand
  import aes_pkg::*;
(
  input  aes_block_t  key,
  input  logic [3:0]  rc,
  output aes_block_t  keyout
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  // Byte 15 is the first FIPS byte, so w0 is the top word.
  assign w0 = key[15:12];
  assign w1 = key[11:8];
  assign w2 = key[7:4];
  assign w3 = key[3:0];

  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon(rc), 24'h0};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign keyout = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key scheduler: one keyexpand round per cycle into an 11-slot store.
// Optional AES_KEY_SCHED_CACHE_EN skips re-expansion when the offered key matches slot0.
//
// state  | meaning
// IDLE   | key_ready high, waiting for a key; slots hold the last schedule
// EXPAND | writing slot[rc+1] from slot[rc] each cycle, rc 0..NUM_ROUNDS-1
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  aes_block_t  key,
  input  logic [3:0]  rk_idx,
  output aes_block_t  rk,
  output logic        keys_valid,
  output logic        done
);

  localparam int NUM_SLOTS = NUM_ROUNDS + 1;

  ks_state_t  state, state_nxt;
  aes_block_t slots [NUM_SLOTS];
  aes_block_t kx_in, kx_out;
  logic [3:0] rc, rc_inc;
  logic       accept, last_round, cache_hit;

  assign rc_inc = rc + 4'd1;

`ifdef AES_KEY_SCHED_CACHE_EN
  assign cache_hit = keys_valid && (key == slots[0]);
`else
  assign cache_hit = 1'b0;
`endif

  keyexpand u_keyexpand (
    .key    (kx_in),
    .rc     (rc),
    .keyout (kx_out)
  );

  always_comb begin
    kx_in = '0;
    rk    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rc == 4'(i))     kx_in = slots[i];
      if (rk_idx == 4'(i)) rk    = slots[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    key_ready  = 1'b0;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        accept    = key_valid;
        if (key_valid && !cache_hit) state_nxt = EXPAND;
      end
      EXPAND: begin
        last_round = (rc == 4'(NUM_ROUNDS - 1));
        if (last_round) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      rc         <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (cache_hit) begin
          done <= 1'b1;
        end else begin
          slots[0]   <= key;
          rc         <= '0;
          keys_valid <= 1'b0;
        end
      end else if (state == EXPAND) begin
        for (int i = 1; i < NUM_SLOTS; i++) begin
          if (rc_inc == 4'(i)) slots[i] <= kx_out;
        end
        rc <= rc_inc;
        if (last_round) begin
          keys_valid <= 1'b1;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler with a round-key scoreboard; cache expectations follow AES_KEY_SCHED_CACHE_EN.
module tb_aes_key_scheduler;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  aes_block_t key = '0;
  logic [3:0] rk_idx = '0;
  aes_block_t rk;
  logic       key_ready, keys_valid, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] idx;
    aes_block_t val;
  } exp_t;
  exp_t sb[$];

  localparam aes_block_t FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_block_t FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam aes_block_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_block_t ZERO_KEY  = 128'h0;
  localparam aes_block_t ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam aes_block_t ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam aes_block_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .keys_valid (keys_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] idx, input aes_block_t val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rk_idx = e.idx;
      #1;
      check($sformatf("rk[%0d]", e.idx), rk, e.val);
    end
  endtask

  // Drives the key for one edge; returns 1ns after the acceptance edge.
  task automatic accept(input string tag, input aes_block_t k);
    check({tag, "_ready_before"}, 128'(key_ready), 128'd1);
    key = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  // Counts edges until done (bounded) and samples where keys_valid was low.
  task automatic wait_done(output int n, output int kv_low);
    n = 0;
    kv_low = 0;
    do begin
      if (!keys_valid) kv_low++;
      step();
      n++;
    end while (!done && n < 40);
  endtask

  int n, kv_low;

  initial begin
    // Reset state
    #12;
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_keys_valid", 128'(keys_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #0.1;
      check($sformatf("rst_rk[%0d]", i), rk, 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // FIPS-197 expansion
    accept("fips", FIPS_KEY);
    check("fips_ready_low", 128'(key_ready), 128'd0);
    check("fips_kv_low", 128'(keys_valid), 128'd0);
    wait_done(n, kv_low);
    check("fips_latency", 128'(n), 128'd10);
    check("fips_kv_low_cycles", 128'(kv_low), 128'd10);
    check("fips_kv_high", 128'(keys_valid), 128'd1);
    check("fips_ready_back", 128'(key_ready), 128'd1);
    push(4'd0, FIPS_KEY);
    push(4'd1, FIPS_RK1);
    push(4'd2, FIPS_RK2);
    push(4'd10, FIPS_RK10);
    push(4'd12, '0);
    drain_sb();
    step();
    check("fips_done_drop", 128'(done), 128'd0);
    check("fips_kv_hold", 128'(keys_valid), 128'd1);

    // Busy handshake: second key held during EXPAND
    key = ZERO_KEY;
    key_valid = 1'b1;
    step();
    key = FIPS_KEY;
    check("busy_ready_low", 128'(key_ready), 128'd0);
    wait_done(n, kv_low);
    check("busy_first_latency", 128'(n), 128'd10);
    rk_idx = 4'd10;
    #1;
    check("busy_first_rk10", rk, ZERO_RK10);
    step();
    key_valid = 1'b0;
    check("busy_second_accepted", 128'(key_ready), 128'd0);
    wait_done(n, kv_low);
    check("busy_done_spacing", 128'(n + 1), 128'd11);
    push(4'd0, FIPS_KEY);
    push(4'd1, FIPS_RK1);
    push(4'd10, FIPS_RK10);
    drain_sb();
    step();

    // Re-offer the same key
    accept("reoffer", FIPS_KEY);
`ifdef AES_KEY_SCHED_CACHE_EN
    check("hit_done", 128'(done), 128'd1);
    check("hit_kv", 128'(keys_valid), 128'd1);
    check("hit_ready", 128'(key_ready), 128'd1);
    step();
    check("hit_done_drop", 128'(done), 128'd0);
    check("hit_kv_hold", 128'(keys_valid), 128'd1);
`else
    check("nocache_kv_low", 128'(keys_valid), 128'd0);
    wait_done(n, kv_low);
    check("nocache_latency", 128'(n), 128'd10);
    check("nocache_kv_low_cycles", 128'(kv_low), 128'd10);
    step();
`endif
    rk_idx = 4'd10;
    #1;
    check("reoffer_rk10", rk, FIPS_RK10);

    // Different key always expands
    accept("newkey", ZERO_KEY);
    check("newkey_kv_low", 128'(keys_valid), 128'd0);
    wait_done(n, kv_low);
    check("newkey_latency", 128'(n), 128'd10);
    check("newkey_kv_low_cycles", 128'(kv_low), 128'd10);
    push(4'd1, ZERO_RK1);
    push(4'd2, ZERO_RK2);
    drain_sb();
    step();

    // Reset in the middle of an expansion
    accept("midrst", FIPS_KEY);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 128'(key_ready), 128'd1);
    check("midrst_kv", 128'(keys_valid), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    rk_idx = 4'd1;
    #1;
    check("midrst_rk1", rk, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    accept("postrst", ZERO_KEY);
    wait_done(n, kv_low);
    check("postrst_latency", 128'(n), 128'd10);
    push(4'd10, ZERO_RK10);
    push(4'd0, ZERO_KEY);
    drain_sb();
    step();
    check("postrst_done_drop", 128'(done), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Iterative AES-128 key-schedule controller. It accepts a cipher key over a valid/ready handshake and time-multiplexes a single `keyexpand` round instance, one round per cycle, with rc 0..9. It stores all 11 round keys (the original key plus 10 expanded keys) in an internal register file. The cipher round engine reads round keys through an indexed read port, gated by `keys_valid`.

## Interface
- `NUM_ROUNDS`, default 10: number of expansion rounds; slots = `NUM_ROUNDS`+1.
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key_valid`, input, 1: a new cipher key is offered on `key`.
- `key_ready`, output, 1: scheduler can accept a key; high only in IDLE.
- `key`, input, [15:0][7:0]: cipher key; byte 15 is FIPS-197 byte 0 (MSB of the 128-bit literal).
- `rk_idx`, input, 4: round-key index 0..10.
- `rk`, output, [15:0][7:0]: round key `rk_idx`, read combinationally from storage.
- `keys_valid`, output, 1: all 11 slots hold keys from the last accepted key.
- `done`, output, 1: one-cycle pulse when an expansion (or cache hit) completes.

## Operation
- FSM states: IDLE, EXPAND. Reset state: IDLE.
- Round counter `rc`, 4 bits, drives the `keyexpand` rc input.
- **IDLE:**
  - A key is accepted when `key_valid && key_ready` at a rising edge.
  - On accept: slot0 ← `key`, `rc` ← 0, `keys_valid` ← 0, go to EXPAND.
- **EXPAND:**
  - Each cycle, `keyexpand(slot[rc], rc)` is written to slot[rc+1] and `rc` increments.
  - When `rc` == `NUM_ROUNDS`-1, the write goes to slot10, `keys_valid` ← 1, `done` pulses, and the FSM returns to IDLE.
- `key_valid` is ignored in EXPAND (`key_ready` = 0). There is no abort and no queueing.
- **Read port:**
  - `rk` = slot[`rk_idx`] for `rk_idx` ≤ 10.
  - `rk_idx` 11..15 returns all-zero.
  - During EXPAND, reads return partial or stale contents; consumers must wait for `keys_valid`.
- `keys_valid` stays high across IDLE until the next key is accepted.

## Timing
- **Reset values:**
  - `key_ready` = 1.
  - `keys_valid` = 0.
  - `done` = 0.
  - `rc` = 0.
  - All slots = 0, so `rk` = 0.
- **Latency:**
  - Acceptance edge = edge 0.
  - slot k is written at edge k (k = 1..10).
  - `keys_valid` and `done` are high after edge 10; `done` drops after edge 11.
- `key_ready` falls after edge 0 and rises with `keys_valid` after edge 10.
- Throughput: one key per 11 cycles. Back-to-back acceptance is possible at edge 11 (`done` cycle) when `key_valid` is held.
- Reset mid-EXPAND: immediate asynchronous return to the reset values above; no partial `keys_valid`.
- The read path is combinational: `rk` changes in the same cycle as `rk_idx`.

## Configuration
- Macro: `AES_KEY_SCHED_CACHE_EN`.
- **Defined:**
  - If `keys_valid` = 1 and `key` == slot0 at acceptance, the FSM stays in IDLE.
  - Slots are untouched, `keys_valid` stays 1, and `done` pulses after the next edge (1-cycle latency).
  - A mismatched key expands normally.
- **Undefined:** every accepted key runs the full 10-cycle expansion; the comparator is not built.

## Structure
- Shared package `aes_pkg` holds:
  - `aes_block_t` (logic [15:0][7:0]).
  - `AES_NUM_ROUNDS` = 10.
  - `AES_NUM_RKEYS` = 11.
  - FSM state enum `ks_state_t` {IDLE, EXPAND}.
- Single sub-module: one instance of the existing `keyexpand` (key, rc, keyout); its output feeds the slot write mux.
- Register file: 11 × `aes_block_t`, write-indexed by `rc`+1, with slot0 written on accept.

## Test plan
- **Reset:** assert `rst_n`=0 → `key_ready`=1, `keys_valid`=0, `done`=0, `rk`=0 for every `rk_idx`.
- **FIPS-197 key expansion:** key 2b7e151628aed2a6abf7158809cf4f3c accepted →
  - `keys_valid` after exactly 10 cycles.
  - `rk_idx`=0 gives the key.
  - `rk_idx`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `rk_idx`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rk_idx`=12 gives 0.
- **Busy handshake:** `key_valid` held with a second key during EXPAND → not accepted until `key_ready`. The second expansion completes 11 cycles after the first `done`, and its slots match the second key's schedule.
- **Reset mid-run:** drop `rst_n` at cycle 5 of EXPAND → outputs return to reset values immediately. After release, a fresh key expands in 10 cycles.
- **Cache hit (`AES_KEY_SCHED_CACHE_EN`):** re-offer the same FIPS key after completion → `done` 1 cycle later, `keys_valid` never drops. A different key causes a 10-cycle expansion and `keys_valid` low during it.
- **Cache build off:** same re-offer → full 10-cycle expansion, `keys_valid` low for 10 cycles.
